// File: rtl/np_iomem_pkg.sv
// Shared constants and FSM state type for the iomem initiator bridge.
package np_iomem_pkg;

    localparam int unsigned IOMEM_AW = 32;
    localparam int unsigned IOMEM_DW = 32;
    localparam int unsigned IOMEM_SW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [IOMEM_SW-1:0] WSTRB_READ = 4'b0000;

endpackage

// File: rtl/np_iomem_initiator_wdog.sv
// Bus watchdog: counts enabled edges since clear, pulses expired on the edge the count reaches LIMIT.
module np_iomem_wdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(LIMIT))) begin
            count <= count + CW'(1);
        end
    end

    // High during the cycle whose closing edge would take the count to LIMIT.
    assign expired = enable && !clear && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/np_iomem_initiator.sv
// Single-beat command to PicoSoC iomem bus master with registered outputs.
// Optional bus timeout is built when NP_IOMEM_TIMEOUT_EN is defined.
module np_iomem_initiator
    import np_iomem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IOMEM_AW-1:0] cmd_addr,
    input  logic [IOMEM_DW-1:0] cmd_wdata,
    input  logic [IOMEM_SW-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IOMEM_DW-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic                iomem_valid,
    input  logic                iomem_ready,
    output logic [IOMEM_AW-1:0] iomem_addr,
    output logic [IOMEM_DW-1:0] iomem_wdata,
    output logic [IOMEM_SW-1:0] iomem_wstrb,
    input  logic [IOMEM_DW-1:0] iomem_rdata
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("np_iomem_initiator: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t              state, state_nx;
    logic                cmd_ready_nx, rsp_valid_nx, rsp_err_nx, iomem_valid_nx;
    logic [IOMEM_DW-1:0] rsp_rdata_nx, iomem_wdata_nx;
    logic [IOMEM_AW-1:0] iomem_addr_nx;
    logic [IOMEM_SW-1:0] iomem_wstrb_nx;
    logic                timeout;

`ifdef NP_IOMEM_TIMEOUT_EN
    np_iomem_wdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .resetn (resetn),
        .clear  (cmd_valid && cmd_ready),
        .enable ((state == ST_BUS) && !iomem_ready),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            iomem_valid <= 1'b0;
            iomem_addr  <= '0;
            iomem_wdata <= '0;
            iomem_wstrb <= '0;
        end else begin
            state       <= state_nx;
            cmd_ready   <= cmd_ready_nx;
            rsp_valid   <= rsp_valid_nx;
            rsp_rdata   <= rsp_rdata_nx;
            rsp_err     <= rsp_err_nx;
            iomem_valid <= iomem_valid_nx;
            iomem_addr  <= iomem_addr_nx;
            iomem_wdata <= iomem_wdata_nx;
            iomem_wstrb <= iomem_wstrb_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        cmd_ready_nx   = cmd_ready;
        rsp_valid_nx   = rsp_valid;
        rsp_rdata_nx   = rsp_rdata;
        rsp_err_nx     = rsp_err;
        iomem_valid_nx = iomem_valid;
        iomem_addr_nx  = iomem_addr;
        iomem_wdata_nx = iomem_wdata;
        iomem_wstrb_nx = iomem_wstrb;

        unique case (state)
            ST_IDLE: begin
                cmd_ready_nx = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_nx   = 1'b0;
                    iomem_valid_nx = 1'b1;
                    iomem_addr_nx  = cmd_addr;
                    iomem_wdata_nx = cmd_wdata;
                    iomem_wstrb_nx = cmd_wstrb;
                    state_nx       = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ready is checked first so a ready on the limit edge still completes.
                if (iomem_ready) begin
                    rsp_rdata_nx   = iomem_rdata;
                    rsp_err_nx     = 1'b0;
                    rsp_valid_nx   = 1'b1;
                    iomem_valid_nx = 1'b0;
                    state_nx       = ST_RESP;
                end else if (timeout) begin
                    rsp_rdata_nx   = '0;
                    rsp_err_nx     = 1'b1;
                    rsp_valid_nx   = 1'b1;
                    iomem_valid_nx = 1'b0;
                    state_nx       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nx = 1'b0;
                    cmd_ready_nx = 1'b1;
                    state_nx     = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_np_iomem_initiator.sv
// Randomized bench for np_iomem_initiator with a transaction-level model and GPIO-style responder.
module tb_np_iomem_initiator;

    localparam int unsigned T = 4;
`ifdef NP_IOMEM_TIMEOUT_EN
    localparam int unsigned LAT_MAX = T + 2;
`else
    localparam int unsigned LAT_MAX = 5;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        iomem_valid, iomem_ready;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
    logic [3:0]  iomem_wstrb;

    np_iomem_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_wstrb(iomem_wstrb), .iomem_rdata(iomem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned lat_q[$];
    int unsigned hold_q[$];
    logic [31:0] mdl  [16];
    logic [31:0] rmem [16];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          late_pulse = 1'b0;

    logic [31:0] last_rdata;
    logic        last_err;
    int unsigned last_lat, last_vcount, last_hs_cyc, last_gap;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
        end
    endfunction

    function automatic void fail_bound(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired, required event never seen", name);
    endfunction

    // Outcome of one command from the bus rules: responder latency vs. abort limit.
    function automatic exp_t predict(input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [3:0] wstrb, input int unsigned lat);
        exp_t        e;
        int unsigned idx;
        idx = {28'd0, addr[5:2]};
`ifdef NP_IOMEM_TIMEOUT_EN
        if ((addr[31:24] != 8'h03) || (lat == 0) || (lat > T)) begin
            e.rdata = '0;
            e.err   = 1'b1;
            e.lat   = T;
            return e;
        end
`endif
        for (int b = 0; b < 4; b++)
            if (wstrb[b]) mdl[idx][8*b +: 8] = wdata[8*b +: 8];
        e.rdata = mdl[idx];
        e.err   = 1'b0;
        e.lat   = lat;
        return e;
    endfunction

    // Responder: ready after 'lat' BUS cycles on the 0x03xx_xxxx page, never elsewhere.
    int unsigned bus_cyc, cur_lat, r_idx;
    initial begin
        iomem_ready = 1'b0;
        iomem_rdata = '0;
        bus_cyc = 0;
        cur_lat = 0;
        forever begin
            @(negedge clk);
            iomem_ready = 1'b0;
            iomem_rdata = $urandom();
            if (!resetn) begin
                bus_cyc = 0;
            end else if (late_pulse) begin
                iomem_ready = 1'b1;
                iomem_rdata = 32'hDEAD_BEEF;
                late_pulse  = 1'b0;
            end else if (iomem_valid) begin
                if (bus_cyc == 0) cur_lat = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
                bus_cyc++;
                if ((iomem_addr[31:24] == 8'h03) && (cur_lat != 0) && (bus_cyc == cur_lat)) begin
                    r_idx = {28'd0, iomem_addr[5:2]};
                    for (int b = 0; b < 4; b++)
                        if (iomem_wstrb[b]) rmem[r_idx][8*b +: 8] = iomem_wdata[8*b +: 8];
                    iomem_rdata = rmem[r_idx];
                    iomem_ready = 1'b1;
                end
            end else begin
                bus_cyc = 0;
            end
        end
    end

    // Response consumer with per-transaction backpressure.
    int unsigned c_hold, c_wait;
    bit          c_have;
    initial begin
        rsp_ready = 1'b0;
        c_have = 1'b0;
        c_hold = 0;
        c_wait = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                rsp_ready = 1'b0;
                c_have    = 1'b0;
            end else if (rsp_valid) begin
                if (!c_have) begin
                    c_hold = (hold_q.size() != 0) ? hold_q.pop_front() : 0;
                    c_wait = 0;
                    c_have = 1'b1;
                end
                if (c_wait >= c_hold) rsp_ready = 1'b1;
                else begin
                    rsp_ready = 1'b0;
                    c_wait++;
                end
            end else begin
                rsp_ready = 1'b0;
                c_have    = 1'b0;
            end
        end
    end

    // Compare process: samples mid-cycle, after the bench drivers have settled.
    int unsigned m_cyc = 0, m_start = 0, m_vcount = 0, m_rlat = 0;
    logic        pv = 1'b0, prv = 1'b0, prr = 1'b0, perr = 1'b0;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pwstrb;
    exp_t        m_e;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            m_cyc++;
            if (!resetn) begin
                pv = 1'b0; prv = 1'b0; prr = 1'b0;
                continue;
            end
            if (iomem_valid && !pv) begin
                m_start  = m_cyc;
                m_vcount = 0;
                last_gap = m_cyc - last_hs_cyc;
            end
            if (iomem_valid) begin
                m_vcount++;
                if (pv) begin
                    chk("iomem_addr_stable", iomem_addr, paddr);
                    chk("iomem_wdata_stable", iomem_wdata, pwdata);
                    chk("iomem_wstrb_stable", {28'd0, iomem_wstrb}, {28'd0, pwstrb});
                end
            end
            if (iomem_valid || rsp_valid) chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
            if (rsp_valid && !prv) begin
                m_rlat = m_cyc - m_start;
                chk("iomem_valid_in_resp", {31'd0, iomem_valid}, 32'd0);
            end
            if (prv && !prr) begin
                chk("rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
                chk("rsp_rdata_held", rsp_rdata, prdata);
                chk("rsp_err_held", {31'd0, rsp_err}, {31'd0, perr});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: actual response present, required none");
                end else begin
                    m_e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, m_e.rdata);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_e.err});
                    chk("rsp_latency", m_rlat, m_e.lat);
                    chk("iomem_valid_cycles", m_vcount, m_e.lat);
                end
                last_rdata  = rsp_rdata;
                last_err    = rsp_err;
                last_lat    = m_rlat;
                last_vcount = m_vcount;
                last_hs_cyc = m_cyc;
            end
            pv = iomem_valid; prv = rsp_valid; prr = rsp_ready;
            paddr = iomem_addr; pwdata = iomem_wdata; pwstrb = iomem_wstrb;
            prdata = rsp_rdata; perr = rsp_err;
        end
    end

    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int unsigned lat, input int unsigned hold);
        int unsigned n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
        while (!cmd_ready) begin
            if (n >= 300) begin
                fail_bound("cmd_accept");
                cmd_valid = 1'b0;
                return;
            end
            n++;
            @(negedge clk);
        end
        exp_q.push_back(predict(addr, wdata, wstrb, lat));
        lat_q.push_back(lat);
        hold_q.push_back(hold);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0) || rsp_valid) begin
            if (n >= 300) begin
                fail_bound("drain");
                return;
            end
            n++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation time bound expired");
        $fatal(1, "global timeout");
    end

    logic [31:0] r_addr;
    int unsigned r_lat;
    logic [3:0]  r_wstrb;
    initial begin
        foreach (mdl[i]) begin
            mdl[i]  = '0;
            rmem[i] = '0;
        end
        last_hs_cyc = 0;
        last_gap    = 0;
        resetn = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        repeat (2) @(negedge clk);
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("reset_iomem_valid", {31'd0, iomem_valid}, 32'd0);
        chk("reset_iomem_addr", iomem_addr, 32'd0);
        chk("reset_iomem_wdata", iomem_wdata, 32'd0);
        chk("reset_iomem_wstrb", {28'd0, iomem_wstrb}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // Full write, readback, partial write.
        issue(32'h0300_0000, 32'h0000_00A5, 4'hF, 1, 0);
        drain();
        chk("wr_rdata", last_rdata, 32'h0000_00A5);
        chk("wr_err", {31'd0, last_err}, 32'd0);
        chk("wr_valid_cycles", last_vcount, 32'd1);
        chk("wr_latency", last_lat, 32'd1);
        issue(32'h0300_0000, 32'h0, 4'h0, 2, 0);
        drain();
        chk("rd_rdata", last_rdata, 32'h0000_00A5);
        chk("rd_latency", last_lat, 32'd2);
        issue(32'h0300_0000, 32'h0000_3C00, 4'b0010, 2, 0);
        issue(32'h0300_0000, 32'h0, 4'h0, 1, 0);
        drain();
        chk("partial_rdata", last_rdata, 32'h0000_3CA5);

        // Backpressure with the next command already waiting.
        issue(32'h0300_0004, 32'h1234_5678, 4'hF, 2, 10);
        issue(32'h0300_0004, 32'h0, 4'h0, 1, 0);
        drain();
        chk("bp_accept_gap", last_gap, 32'd2);
        chk("bp_readback", last_rdata, 32'h1234_5678);

`ifdef NP_IOMEM_TIMEOUT_EN
        issue(32'h0400_0000, 32'hFFFF_FFFF, 4'hF, 1, 4);
        begin
            int unsigned n;
            n = 0;
            while (!rsp_valid && (n < 50)) begin
                n++;
                @(negedge clk);
            end
            if (!rsp_valid) fail_bound("timeout_rsp");
        end
        late_pulse = 1'b1;
        drain();
        chk("to_err", {31'd0, last_err}, 32'd1);
        chk("to_rdata", last_rdata, 32'd0);
        chk("to_valid_cycles", last_vcount, 32'd4);
        issue(32'h0300_0008, 32'h0000_0077, 4'h1, 4, 0);
        drain();
        chk("limit_edge_err", {31'd0, last_err}, 32'd0);
        chk("limit_edge_rdata", last_rdata, 32'h0000_0077);
`endif

        // Reset while the bus request is outstanding.
        issue(32'h0300_000C, 32'h0, 4'h0, 0, 0);
        @(negedge clk);
        chk("pre_rst_iomem_valid", {31'd0, iomem_valid}, 32'd1);
        #3 resetn = 1'b0;
        #1;
        chk("rst_iomem_valid", {31'd0, iomem_valid}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_iomem_addr", iomem_addr, 32'd0);
        exp_q.delete();
        lat_q.delete();
        hold_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_midop_reset", {31'd0, cmd_ready}, 32'd1);
        issue(32'h0300_0000, 32'h0, 4'h0, 2, 0);
        drain();
        chk("post_rst_rdata", last_rdata, 32'h0000_3CA5);

        for (int k = 0; k < 60; k++) begin
            r_addr = 32'h0300_0000 + 32'(4 * $urandom_range(0, 15));
`ifdef NP_IOMEM_TIMEOUT_EN
            if ($urandom_range(0, 9) == 0) r_addr = 32'h0400_0000 + 32'(4 * $urandom_range(0, 15));
`endif
            r_lat   = $urandom_range(1, LAT_MAX);
            r_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom()) : 4'h0;
            issue(r_addr, $urandom(), r_wstrb, r_lat, $urandom_range(0, 3));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
